// File: rtl/sat_sub_serial.sv
// sat_sub_serial
// ---------------
// Digit-serial saturating two's-complement subtractor: result = sat(x - y).
// The subtraction is done as x + ~y + 1, one DIGIT-wide slice per cycle,
// LSB digit first. Once every digit has been summed, the sign rule decides
// whether the raw difference wrapped. If it did, the result is clamped to
// the most positive or most negative representable value.
// BIT_WIDTH must be a multiple of DIGIT.
//
// Ports:
//   clk     single clock, all state changes on the rising edge
//   reset   synchronous, active-high; aborts any in-flight operation
//   start   request, sampled only while idle; never queued
//   x, y    signed minuend / subtrahend, captured on the accept edge
//   result  saturated difference, registered, held until next completion
//   ovf     high when the held result was saturated
//   busy    high whenever an operation is in flight (not idle)
//   done    one-cycle pulse, result/ovf valid in the same cycle
module sat_sub_serial #(
  parameter int BIT_WIDTH = 16,
  parameter int DIGIT     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BIT_WIDTH-1:0] x,
  input  logic [BIT_WIDTH-1:0] y,
  output logic [BIT_WIDTH-1:0] result,
  output logic                 ovf,
  output logic                 busy,
  output logic                 done
);

  localparam int N     = BIT_WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int MSB   = BIT_WIDTH - 1;

  localparam logic [BIT_WIDTH-1:0] MAX_POS = {1'b0, {(BIT_WIDTH-1){1'b1}}};
  localparam logic [BIT_WIDTH-1:0] MIN_NEG = {1'b1, {(BIT_WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0]     LAST_DIGIT = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SAT,
    DONE
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic                 carry;
  logic [BIT_WIDTH-1:0] xr;
  logic [BIT_WIDTH-1:0] yr;
  logic [BIT_WIDTH-1:0] diff;

  int                   digit_base;
  logic [DIGIT-1:0]     x_digit;
  logic [DIGIT-1:0]     y_digit;
  logic [DIGIT:0]       digit_sum;
  logic                 sx;
  logic                 sy;
  logic                 sd;
  logic                 sat_ovf;

  // One digit of the running add. The extra top bit of digit_sum is the
  // carry that ripples into the next digit on the following cycle.
  always_comb begin
    digit_base = int'(cnt) * DIGIT;
    x_digit    = xr[digit_base +: DIGIT];
    y_digit    = yr[digit_base +: DIGIT];
    digit_sum  = {1'b0, x_digit} + {1'b0, y_digit} + {{DIGIT{1'b0}}, carry};
  end

  // yr holds ~y, so the subtrahend's original sign is the inverse of its
  // MSB. Overflow is only possible when the operand signs differ, and it
  // shows up as a result whose sign disagrees with the minuend.
  always_comb begin
    sx      = xr[MSB];
    sy      = ~yr[MSB];
    sd      = diff[MSB];
    sat_ovf = (sx != sy) && (sd != sx);
  end

  // Control FSM and datapath registers. The outputs busy and done are
  // registered here too, so they change only on clock edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      xr     <= '0;
      yr     <= '0;
      diff   <= '0;
      result <= '0;
      ovf    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            xr    <= x;
            yr    <= ~y;
            carry <= 1'b1;
            cnt   <= '0;
            diff  <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          diff[digit_base +: DIGIT] <= digit_sum[DIGIT-1:0];
          carry                     <= digit_sum[DIGIT];
          if (cnt == LAST_DIGIT) begin
            state <= SAT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SAT: begin
          // The final carry-out is dropped; only the sign rule matters.
          if (sat_ovf) begin
            result <= sx ? MIN_NEG : MAX_POS;
            ovf    <= 1'b1;
          end else begin
            result <= diff;
            ovf    <= 1'b0;
          end
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sat_sub_serial.sv
// tb_sat_sub_serial
// -----------------
// Self-checking bench for sat_sub_serial. A behavioural model computes
// sat(x - y) with plain integer arithmetic. Handshake timing, result
// holding, abort-on-reset and back-to-back start behaviour are all
// checked against what the bench itself expects.
module tb_sat_sub_serial;

  localparam int W     = 16;
  localparam int DIGIT = 4;
  localparam int N     = W / DIGIT;
  localparam int NUM_RANDOM = 3000;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [W-1:0] result;
  logic         ovf;
  logic         busy;
  logic         done;

  int checks;
  int errors;

  logic [W-1:0] lastResult;
  logic         lastOvf;

  sat_sub_serial #(
    .BIT_WIDTH(W),
    .DIGIT(DIGIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .x(x),
    .y(y),
    .result(result),
    .ovf(ovf),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts every comparison and reports any mismatch on a single line.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: exact signed difference, clamped to the W-bit range.
  function automatic void satSubModel(input logic [W-1:0] a,
                                      input logic [W-1:0] b,
                                      output logic [W-1:0] r,
                                      output logic o);
    longint d;
    longint maxV;
    longint minV;
    d    = longint'($signed(a)) - longint'($signed(b));
    maxV = (longint'(1) <<< (W - 1)) - 1;
    minV = -maxV - 1;
    if (d > maxV) begin
      r = W'(maxV);
      o = 1'b1;
    end else if (d < minV) begin
      r = W'(minV);
      o = 1'b1;
    end else begin
      r = W'(d);
      o = 1'b0;
    end
  endfunction

  // Runs one full operation from an idle DUT and checks the handshake,
  // the held result before done, latency, busy length and the answer.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] expRes;
    logic         expOvf;
    int           k;
    int           busyCnt;
    int           doneAt;
    satSubModel(a, b, expRes, expOvf);
    @(negedge clk);
    start = 1'b1;
    x     = a;
    y     = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    x     = W'($urandom);
    y     = W'($urandom);
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
    busyCnt = 1;
    doneAt  = 0;
    k       = 0;
    while (doneAt == 0 && k < 12) begin
      @(posedge clk);
      #1;
      k++;
      if (busy) busyCnt++;
      if (done) begin
        doneAt = k;
      end else begin
        checkOutput("result_hold", 32'(result), 32'(lastResult));
        checkOutput("ovf_hold", 32'(ovf), 32'(lastOvf));
      end
    end
    if (doneAt == 0) begin
      checkOutput("done_timeout", 32'd0, 32'd1);
    end else begin
      checkOutput("latency", 32'(doneAt), 32'(N + 1));
      checkOutput("result", 32'(result), 32'(expRes));
      checkOutput("ovf", 32'(ovf), 32'(expOvf));
      @(posedge clk);
      #1;
      if (busy) busyCnt++;
      checkOutput("busy_cycles", 32'(busyCnt), 32'(N + 2));
      checkOutput("done_single", 32'(done), 32'd0);
    end
    lastResult = expRes;
    lastOvf    = expOvf;
  endtask

  // Keeps start high while x/y change every cycle. The bench knows the
  // DUT accepts every N+3 edges, so it records the operands on each edge
  // and expects done exactly N+1 edges after each accept.
  task automatic holdStartTest();
    localparam int EDGES  = 28;
    localparam int PERIOD = N + 3;
    logic [W-1:0] xs[EDGES];
    logic [W-1:0] ys[EDGES];
    logic [W-1:0] expRes;
    logic         expOvf;
    bit           expDone;
    for (int e = 0; e < EDGES; e++) begin
      @(negedge clk);
      start = 1'b1;
      x     = W'($urandom);
      y     = W'($urandom);
      xs[e] = x;
      ys[e] = y;
      @(posedge clk);
      #1;
      expDone = (e >= N + 1) && (((e - (N + 1)) % PERIOD) == 0);
      checkOutput("hold_done", 32'(done), 32'(expDone));
      if (expDone) begin
        satSubModel(xs[e - (N + 1)], ys[e - (N + 1)], expRes, expOvf);
        checkOutput("hold_result", 32'(result), 32'(expRes));
        checkOutput("hold_ovf", 32'(ovf), 32'(expOvf));
        lastResult = expRes;
        lastOvf    = expOvf;
      end
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("hold_idle", 32'(busy), 32'd0);
  endtask

  // Aborts an operation two digits in and checks that it leaves no trace.
  task automatic resetAbortTest();
    int doneSeen;
    @(negedge clk);
    start = 1'b1;
    x     = 16'h4000;
    y     = 16'h0123;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_result", 32'(result), 32'd0);
    checkOutput("abort_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done) doneSeen++;
    end
    checkOutput("abort_no_done", 32'(doneSeen), 32'd0);
    lastResult = '0;
    lastOvf    = 1'b0;
  endtask

  // Random operands, with corner values mixed in to hit saturation often.
  function automatic logic [W-1:0] pickOperand();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = {1'b0, {(W-1){1'b1}}};
      1:       v = {1'b1, {(W-1){1'b0}}};
      2:       v = '1;
      3:       v = '0;
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    checks     = 0;
    errors     = 0;
    lastResult = '0;
    lastOvf    = 1'b0;
    reset      = 1'b1;
    start      = 1'b0;
    x          = '0;
    y          = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_result", 32'(result), 32'd0);
    checkOutput("reset_ovf", 32'(ovf), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] directed operations");
    applyStimulus(16'h0005, 16'h0003);
    applyStimulus(16'h7FFF, 16'hFFFF);
    applyStimulus(16'h8000, 16'h0001);
    applyStimulus(16'h1234, 16'h1234);
    applyStimulus(16'h0000, 16'h8000);
    applyStimulus(16'hFFFF, 16'h8000);
    applyStimulus(16'h8000, 16'h7FFF);
    applyStimulus(16'h7FFF, 16'h8000);

    $display("[TB] start held high");
    holdStartTest();

    $display("[TB] reset mid-operation");
    resetAbortTest();
    applyStimulus(16'h0100, 16'h0001);

    $display("[TB] randomized operations");
    for (int i = 0; i < NUM_RANDOM; i++) begin
      applyStimulus(pickOperand(), pickOperand());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends even if the DUT misbehaves.
  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
